// File: rtl/regfile_bank_if.sv
// Register-file access bus: writeback port plus two combinational read ports.
//   RegWrite       write enable, sampled on rising clk
//   WriteRegister  destination register index (5 bits)
//   WriteData      data to write
//   ReadRegister1  read port 1 index
//   ReadRegister2  read port 2 index
//   ReadData1      contents of ReadRegister1
//   ReadData2      contents of ReadRegister2
// master: pipeline side (drives writes and read addresses); slave: register file.
interface regfile_bank_if #(
    parameter int unsigned WIDTH = 64
);
    logic             RegWrite;
    logic [4:0]       WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic [4:0]       ReadRegister1;
    logic [4:0]       ReadRegister2;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;

    modport master (
        output RegWrite,
        output WriteRegister,
        output WriteData,
        output ReadRegister1,
        output ReadRegister2,
        input  ReadData1,
        input  ReadData2
    );

    modport slave (
        input  RegWrite,
        input  WriteRegister,
        input  WriteData,
        input  ReadRegister1,
        input  ReadRegister2,
        output ReadData1,
        output ReadData2
    );
endinterface

// File: rtl/regfile_bank.sv
// CPU register file storage: 32 x WIDTH architectural registers, X31 hardwired zero.
// One write port (writeback stage), two combinational read ports (decode stage).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears the array and forces reads to zero
//   bus    regfile_bank_if.slave (RegWrite/WriteRegister/WriteData in,
//          ReadRegister1/2 in, ReadData1/2 out)
// Build option: define REGFILE_BYPASS_EN for write-through forwarding, where a
// read of the register being written this cycle returns WriteData directly.
module regfile_bank #(
    parameter int unsigned WIDTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    regfile_bank_if.slave   bus
);
    localparam int unsigned NREGS    = 32;
    localparam int unsigned ZERO_REG = 31;
    localparam int unsigned AW       = 5;

    // Leaf cells of the read trees.
    function automatic logic [WIDTH-1:0] mux2_1(
        input logic             sel,
        input logic [WIDTH-1:0] d0,
        input logic [WIDTH-1:0] d1
    );
        return sel ? d1 : d0;
    endfunction

    function automatic logic [WIDTH-1:0] mux4_1(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] d0,
        input logic [WIDTH-1:0] d1,
        input logic [WIDTH-1:0] d2,
        input logic [WIDTH-1:0] d3
    );
        logic [WIDTH-1:0] y;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
        return y;
    endfunction

    function automatic logic [WIDTH-1:0] mux8_1(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] d0,
        input logic [WIDTH-1:0] d1,
        input logic [WIDTH-1:0] d2,
        input logic [WIDTH-1:0] d3,
        input logic [WIDTH-1:0] d4,
        input logic [WIDTH-1:0] d5,
        input logic [WIDTH-1:0] d6,
        input logic [WIDTH-1:0] d7
    );
        logic [WIDTH-1:0] y;
        case (sel)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            3'd5:    y = d5;
            3'd6:    y = d6;
            default: y = d7;
        endcase
        return y;
    endfunction

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] write_en;

    // 5:32 one-hot write decode; the zero register never gets an enable.
    always_comb begin
        write_en = '0;
        if (bus.RegWrite) begin
            write_en[bus.WriteRegister] = 1'b1;
        end
        write_en[ZERO_REG] = 1'b0;
    end

    // Register array; entry ZERO_REG is never enabled so it stays at its reset value 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (write_en[i]) begin
                    regs[i] <= bus.WriteData;
                end
            end
        end
    end

    logic [WIDTH-1:0] grp1 [4];
    logic [WIDTH-1:0] grp2 [4];
    logic [WIDTH-1:0] tree1;
    logic [WIDTH-1:0] tree2;

    // 32:1 read trees: mux8 on address bits [2:0] per group of eight, then mux4 on [4:3].
    always_comb begin
        for (int g = 0; g < 4; g++) begin
            grp1[g] = mux8_1(bus.ReadRegister1[2:0],
                             regs[8*g+0], regs[8*g+1], regs[8*g+2], regs[8*g+3],
                             regs[8*g+4], regs[8*g+5], regs[8*g+6], regs[8*g+7]);
            grp2[g] = mux8_1(bus.ReadRegister2[2:0],
                             regs[8*g+0], regs[8*g+1], regs[8*g+2], regs[8*g+3],
                             regs[8*g+4], regs[8*g+5], regs[8*g+6], regs[8*g+7]);
        end
        tree1 = mux4_1(bus.ReadRegister1[4:3], grp1[0], grp1[1], grp1[2], grp1[3]);
        tree2 = mux4_1(bus.ReadRegister2[4:3], grp2[0], grp2[1], grp2[2], grp2[3]);
    end

    logic [WIDTH-1:0] port1;
    logic [WIDTH-1:0] port2;

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    logic hit1;
    logic hit2;

    // Forward the in-flight writeback to a port reading the same (non-zero) register.
    always_comb begin
        wr_live = bus.RegWrite && (bus.WriteRegister != AW'(ZERO_REG));
        hit1    = wr_live && (bus.ReadRegister1 == bus.WriteRegister);
        hit2    = wr_live && (bus.ReadRegister2 == bus.WriteRegister);
        port1   = mux2_1(hit1, tree1, bus.WriteData);
        port2   = mux2_1(hit2, tree2, bus.WriteData);
    end
`else
    always_comb begin
        port1 = tree1;
        port2 = tree2;
    end
`endif

    // Reset forces both ports to zero, which also suppresses any forwarding.
    assign bus.ReadData1 = mux2_1(reset, port1, '0);
    assign bus.ReadData2 = mux2_1(reset, port2, '0);
endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: directed vector table, hand-written
// reset/bypass/zero-register sequences, and random traffic against an array model.
module tb_regfile_bank;
    localparam int unsigned WIDTH = 64;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    regfile_bank_if #(.WIDTH(WIDTH)) bus ();

    regfile_bank #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view: X0..X31, X31 reads zero.
    logic [WIDTH-1:0] model [32];

    typedef struct {
        logic             we;
        logic [4:0]       wa;
        logic [WIDTH-1:0] wd;
        logic [4:0]       ra1;
        logic [4:0]       ra2;
        logic [WIDTH-1:0] exp1;
        logic [WIDTH-1:0] exp2;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] exp_read(input logic [4:0] addr);
        if (reset) return '0;
        if (addr == 5'd31) return '0;
        if (BYP && bus.RegWrite && bus.WriteRegister == addr) return bus.WriteData;
        return model[addr];
    endfunction

    task automatic model_write();
        if (!reset && bus.RegWrite && bus.WriteRegister != 5'd31)
            model[bus.WriteRegister] = bus.WriteData;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        reset             = 1'b1;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd31;

        vecs[0] = '{1'b1, 5'd3,  64'h0123_4567_89AB_CDEF, 5'd3, 5'd3,
                    64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{1'b1, 5'd31, {WIDTH{1'b1}}, 5'd31, 5'd31, 64'h0, 64'h0};
        vecs[2] = '{1'b1, 5'd7,  64'h77, 5'd7, 5'd3, 64'h77, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{1'b0, 5'd7,  64'h55, 5'd7, 5'd31, 64'h77, 64'h0};
        vecs[4] = '{1'b1, 5'd0,  64'hFFFF_0000_FFFF_0000, 5'd0, 5'd7,
                    64'hFFFF_0000_FFFF_0000, 64'h77};

        // Reset state
        #2;
        check("reset_rd1", bus.ReadData1, 64'h0);
        check("reset_rd2", bus.ReadData2, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_reset_x0", bus.ReadData1, 64'h0);

        // Directed vector table: write on one edge, read back after it
        for (int v = 0; v < 5; v++) begin
            bus.RegWrite      = vecs[v].we;
            bus.WriteRegister = vecs[v].wa;
            bus.WriteData     = vecs[v].wd;
            bus.ReadRegister1 = vecs[v].ra1;
            bus.ReadRegister2 = vecs[v].ra2;
            tick();
            model_write_after_edge(vecs[v].we, vecs[v].wa, vecs[v].wd);
            bus.RegWrite = 1'b0;
            #1;
            check($sformatf("vec%0d_rd1", v), bus.ReadData1, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), bus.ReadData2, vecs[v].exp2);
        end

        // Same-cycle write/read of X9 (old value 1)
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd9; bus.WriteData = 64'h1;
        tick();
        model[9] = 64'h1;
        bus.WriteData     = 64'hA5A5;
        bus.ReadRegister2 = 5'd9;
        #1;
        check("same_cycle_pre_edge", bus.ReadData2, BYP ? 64'hA5A5 : 64'h1);
        tick();
        model[9] = 64'hA5A5;
        bus.RegWrite = 1'b0;
        #1;
        check("same_cycle_post_edge", bus.ReadData2, 64'hA5A5);

        // Bypass must never forward a write aimed at X31
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd31; bus.WriteData = 64'hBAD;
        bus.ReadRegister1 = 5'd31;
        #1;
        check("x31_no_forward", bus.ReadData1, 64'h0);
        tick();
        bus.RegWrite = 1'b0;

        // Mid-run asynchronous reset with X5=0xDEAD stored
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd5; bus.WriteData = 64'hDEAD;
        tick();
        model[5] = 64'hDEAD;
        bus.RegWrite = 1'b0;
        bus.ReadRegister1 = 5'd5;
        #1;
        check("x5_before_reset", bus.ReadData1, 64'hDEAD);
        #1;
        reset = 1'b1;
        bus.RegWrite = 1'b1; bus.WriteRegister = 5'd5; bus.WriteData = 64'hBEEF;
        bus.ReadRegister2 = 5'd5;
        #1;
        check("async_reset_rd1", bus.ReadData1, 64'h0);
        check("async_reset_rd2_no_bypass", bus.ReadData2, 64'h0);
        tick();
        reset = 1'b0;
        bus.RegWrite = 1'b0;
        model_clear();
        #1;
        check("reset_beats_write", bus.ReadData1, 64'h0);

        // Fill X0..X30 with i*0x0101, read pairs (i, 30-i)
        for (int i = 0; i < 31; i++) begin
            bus.RegWrite = 1'b1;
            bus.WriteRegister = 5'(i);
            bus.WriteData = 64'(i * 32'h0101);
            tick();
            model[i] = 64'(i * 32'h0101);
        end
        bus.RegWrite = 1'b0;
        for (int i = 0; i < 31; i++) begin
            bus.ReadRegister1 = 5'(i);
            bus.ReadRegister2 = 5'(30 - i);
            #1;
            check($sformatf("fill_rd1_x%0d", i), bus.ReadData1, 64'(i * 32'h0101));
            check($sformatf("fill_rd2_x%0d", 30 - i), bus.ReadData2, 64'((30 - i) * 32'h0101));
        end
        bus.ReadRegister1 = 5'd31;
        #1;
        check("fill_x31", bus.ReadData1, 64'h0);

        // Random traffic against the model, checked just before each edge
        for (int n = 0; n < 400; n++) begin
            bus.RegWrite      = 1'($urandom_range(0, 1));
            bus.WriteRegister = 5'($urandom);
            bus.WriteData     = {$urandom, $urandom};
            bus.ReadRegister1 = 5'($urandom);
            bus.ReadRegister2 = ($urandom_range(0, 3) == 0) ? bus.WriteRegister : 5'($urandom);
            #1;
            check($sformatf("rand%0d_rd1", n), bus.ReadData1, exp_read(bus.ReadRegister1));
            check($sformatf("rand%0d_rd2", n), bus.ReadData2, exp_read(bus.ReadRegister2));
            tick();
            model_write();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic model_write_after_edge(input logic we, input logic [4:0] wa, input logic [WIDTH-1:0] wd);
        if (we && wa != 5'd31) model[wa] = wd;
    endtask
endmodule
